// File: rtl/pic_ack_sequencer.sv
// Control sequencer for an 8259-compatible PIC: rotating-priority resolution,
// INT generation, 8086-mode two-pulse INTA handshake and OCW2 EOI/rotation decode.
module pic_ack_sequencer #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       interrupt_request,
  input  logic [7:0]       in_service_register,
  input  logic [7:0]       highest_level_in_service,
  input  logic             inta_n,
  input  logic             ocw2_write,
  input  logic [7:0]       ocw2_data,
  input  logic             auto_eoi,
  input  logic [4:0]       vector_base,
  output logic             int_out,
  output logic [7:0]       interrupt,
  output logic [7:0]       end_of_interrupt,
  output logic [7:0]       clear_interrupt_request,
  output logic [2:0]       priority_rotate,
  output logic [VEC_W-1:0] vector_out,
  output logic             vector_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK1 = 2'd1;
  localparam logic [1:0] S_ACK2 = 2'd2;

  logic [1:0]       r_state;
  logic             r_inta_hist;
  logic             r_int_out;
  logic [2:0]       r_acked_level;
  logic             r_spurious;
  logic [7:0]       r_interrupt;
  logic [7:0]       r_clear_irq;
  logic [7:0]       r_eoi;
  logic [2:0]       r_priority_rotate;
  logic             r_rotate_in_aeoi;
  logic [VEC_W-1:0] r_vector_out;
  logic             r_vector_valid;

  logic             w_fall;
  logic             w_rise;
  logic [2:0]       w_best_level;
  logic [2:0]       w_best_rank;
  logic [2:0]       w_his_idx;
  logic [2:0]       w_his_rank;
  logic             w_req_valid;
  logic [7:0]       w_ocw_eoi_mask;
  logic             w_ocw_rot_en;
  logic [2:0]       w_ocw_rot_val;
  logic             w_aeoi_set;
  logic             w_aeoi_clr;
  logic             w_aeoi_fire;
  logic [7:0]       w_aeoi_mask;
  logic [7:0]       w_ocw_l_onehot;

  // ISR contents are tracked by the register block; only the highest level matters here
  logic             w_unused_isr;
  assign w_unused_isr = ^in_service_register;

  assign w_fall = r_inta_hist & ~inta_n;
  assign w_rise = ~r_inta_hist & inta_n;

  // Walk from lowest to highest priority so the highest-ranked request wins last
  always_comb begin
    w_best_level = 3'd7;
    w_best_rank  = 3'd7;
    for (int k = 7; k >= 0; k--) begin
      if (interrupt_request[r_priority_rotate + 3'(k) + 3'd1]) begin
        w_best_level = r_priority_rotate + 3'(k) + 3'd1;
        w_best_rank  = 3'(k);
      end
    end
  end

  always_comb begin
    w_his_idx = 3'd0;
    for (int n = 0; n < 8; n++) begin
      if (highest_level_in_service[n]) w_his_idx = 3'(n);
    end
  end

  assign w_his_rank  = w_his_idx - r_priority_rotate - 3'd1;
  assign w_req_valid = (|interrupt_request) &&
                       ((highest_level_in_service == 8'd0) || (w_best_rank < w_his_rank));

  assign w_ocw_l_onehot = 8'd1 << ocw2_data[2:0];

  // OCW2 command is ocw2_data[7:5] = {R, SL, EOI}
  always_comb begin
    w_ocw_eoi_mask = 8'd0;
    w_ocw_rot_en   = 1'b0;
    w_ocw_rot_val  = ocw2_data[2:0];
    w_aeoi_set     = 1'b0;
    w_aeoi_clr     = 1'b0;
    if (ocw2_write) begin
      case (ocw2_data[7:5])
        3'b001: w_ocw_eoi_mask = highest_level_in_service;
        3'b011: w_ocw_eoi_mask = w_ocw_l_onehot;
        3'b101: begin
          w_ocw_eoi_mask = highest_level_in_service;
          w_ocw_rot_en   = |highest_level_in_service;
          w_ocw_rot_val  = w_his_idx;
        end
        3'b111: begin
          w_ocw_eoi_mask = w_ocw_l_onehot;
          w_ocw_rot_en   = 1'b1;
        end
        3'b110: w_ocw_rot_en = 1'b1;
        3'b100: w_aeoi_set   = 1'b1;
        3'b000: w_aeoi_clr   = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_aeoi_fire = (r_state == S_ACK2) && w_rise && auto_eoi && !r_spurious;
  assign w_aeoi_mask = w_aeoi_fire ? (8'd1 << r_acked_level) : 8'd0;

  // Priority rotation and EOI pulse; an OCW2 rotation overrides the AEOI rotation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_priority_rotate <= 3'd7;
      r_rotate_in_aeoi  <= 1'b0;
      r_eoi             <= 8'd0;
    end else begin
      r_eoi <= w_ocw_eoi_mask | w_aeoi_mask;
      if (w_ocw_rot_en)
        r_priority_rotate <= w_ocw_rot_val;
      else if (w_aeoi_fire && r_rotate_in_aeoi)
        r_priority_rotate <= r_acked_level;
      if (w_aeoi_set)
        r_rotate_in_aeoi <= 1'b1;
      else if (w_aeoi_clr)
        r_rotate_in_aeoi <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_inta_hist    <= 1'b1;
      r_int_out      <= 1'b0;
      r_acked_level  <= 3'd0;
      r_spurious     <= 1'b0;
      r_interrupt    <= 8'd0;
      r_clear_irq    <= 8'd0;
      r_vector_out   <= '0;
      r_vector_valid <= 1'b0;
    end else begin
      r_inta_hist <= inta_n;
      r_interrupt <= 8'd0;
      r_clear_irq <= 8'd0;
      case (r_state)
        S_IDLE: begin
          r_int_out <= w_req_valid;
          if (w_fall) begin
            r_int_out <= 1'b0;
            r_state   <= S_ACK1;
            if (w_req_valid) begin
              r_acked_level <= w_best_level;
              r_spurious    <= 1'b0;
              r_interrupt   <= 8'd1 << w_best_level;
              r_clear_irq   <= 8'd1 << w_best_level;
            end else begin
              r_acked_level <= 3'd7;
              r_spurious    <= 1'b1;
            end
          end
        end
        S_ACK1: begin
          r_int_out <= 1'b0;
          if (w_fall) begin
            r_state        <= S_ACK2;
            r_vector_out   <= {vector_base, r_acked_level};
            r_vector_valid <= 1'b1;
          end
        end
        S_ACK2: begin
          r_int_out <= 1'b0;
          if (w_rise) begin
            r_state        <= S_IDLE;
            r_vector_valid <= 1'b0;
            r_vector_out   <= '0;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_int_out      <= 1'b0;
          r_vector_valid <= 1'b0;
        end
      endcase
    end
  end

  assign int_out                 = r_int_out;
  assign interrupt               = r_interrupt;
  assign end_of_interrupt        = r_eoi;
  assign clear_interrupt_request = r_clear_irq;
  assign priority_rotate         = r_priority_rotate;
  assign vector_out              = r_vector_out;
  assign vector_valid            = r_vector_valid;

endmodule

// File: doc/pic_ack_sequencer.md
Name: pic_ack_sequencer

Overview:
- Control block for the 8259-compatible PIC.
- Resolves pending masked requests against the in-service state under rotating priority, raises INT to the CPU, and sequences the two-pulse 8086-mode INTA handshake.
- Drives the in-service register's set and EOI pulses and supplies the interrupt vector.
- Decodes OCW2 commands: EOI, specific EOI, rotation and set-priority.

Parameters:
- VEC_W, 8, width of vector_out; fixed at 8 (8086 mode). Reserved, no other value supported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- interrupt_request  in  8  pending requests, already masked by IMR
- in_service_register  in  8  current ISR contents
- highest_level_in_service  in  8  one-hot highest in-service level (0 = none)
- inta_n  in  1  CPU acknowledge, active low, already synchronised to clk
- ocw2_write  in  1  single-cycle OCW2 write strobe
- ocw2_data  in  8  OCW2 byte: [7:5] = R,SL,EOI; [2:0] = L
- auto_eoi  in  1  ICW4 AEOI mode
- vector_base  in  5  ICW2 T7..T3
- int_out  out  1  interrupt request to CPU
- interrupt  out  8  one-hot ISR set pulse, 1 cycle
- end_of_interrupt  out  8  one-hot ISR clear pulse, 1 cycle
- clear_interrupt_request  out  8  one-hot IRR clear pulse, 1 cycle
- priority_rotate  out  3  lowest-priority level; 7 means IR0 is highest
- vector_out  out  8  {vector_base, level}
- vector_valid  out  1  data-bus drive enable for vector_out

Behaviour:
- Reset (async, rst=0): state IDLE; priority_rotate=3'b111; rotate_in_aeoi=0; all other outputs 0; internal inta_n history register=1.
- Priority rank of level n: (n - priority_rotate - 1) mod 8, where 0 is highest.
  - best_req: highest-ranked bit of interrupt_request.
  - Request is valid when best_req rank < rank of highest_level_in_service, or highest_level_in_service == 0.
- INTA edges: fall = history 1 and inta_n 0; rise = history 0 and inta_n 1. History is registered every cycle.
- FSM:
  - IDLE:
    - int_out is registered. It is 1 the cycle after a valid request exists and 0 otherwise.
    - On fall: latch acked_level=best_req and go to ACK1.
    - If the request was valid at the fall: pulse interrupt[acked] and clear_interrupt_request[acked] in the next cycle.
    - If no valid request at the fall (spurious): acked_level=7, no pulses, spurious flag set.
  - ACK1:
    - int_out=0.
    - On fall: go to ACK2; vector_out={vector_base, acked_level} and vector_valid=1 from the next cycle.
  - ACK2:
    - vector_valid stays 1 while inta_n=0.
    - On rise: vector_valid=0 and return to IDLE.
    - If auto_eoi=1 and not spurious: pulse end_of_interrupt[acked] in the same cycle. If rotate_in_aeoi is also set, priority_rotate<=acked_level.
  - Rises in IDLE/ACK1 are ignored. Falls in ACK2 are ignored.
- OCW2, decoded on ocw2_write in any state, effects 1 cycle later:
  - 001 non-specific EOI: end_of_interrupt=highest_level_in_service. Nothing happens if it is 0.
  - 011 specific EOI: end_of_interrupt=onehot(L).
  - 101 rotate on non-specific EOI: non-specific EOI plus priority_rotate<=index(highest_level_in_service). No rotation if it is 0.
  - 111 rotate on specific EOI: end_of_interrupt=onehot(L) and priority_rotate<=L.
  - 110 set priority: priority_rotate<=L, no EOI.
  - 100 sets rotate_in_aeoi; 000 clears it; 010 is a no-op.
- Simultaneous OCW2 EOI and AEOI pulse: end_of_interrupt is the OR of both masks; the OCW2 rotation wins over the AEOI rotation.
- The ISR set pulse and an EOI pulse may coincide; the ISR handles this as clear then set.
- Reset mid-handshake: immediate return to IDLE, vector_valid=0, no pending pulses survive.
- All pulses are exactly 1 cycle wide regardless of inta_n pulse width.

Test Plan:
1. Reset, interrupt_request=8'h08, ISR=0, vector_base=5'h11. Two INTA pulses produce:
   - int_out=1, then interrupt=8'h08 and clear_interrupt_request=8'h08 for 1 cycle after the first fall;
   - vector_out=8'h8B with vector_valid=1 during the second pulse;
   - int_out=0 after the first fall.
2. Nesting: highest_level_in_service=8'h04 with request 8'h10 gives int_out=0. Request 8'h02 gives int_out=1.
3. OCW2 8'hC4 (set priority, L=4), then requests 8'h21: IR5 is acked. Vector low bits are 3'b101 and priority_rotate=4.
4. auto_eoi=1 with rotate_in_aeoi set via 8'h80, request IR2. On the second INTA rise:
   - end_of_interrupt=8'h04 for 1 cycle;
   - priority_rotate=2.
5. Spurious case: the request drops before the first INTA fall. No interrupt pulse, vector low bits=7, no AEOI pulse.
6. OCW2 8'hA0 with highest_level_in_service=8'h40 coinciding with an AEOI pulse for IR1:
   - end_of_interrupt=8'h42;
   - priority_rotate=6.
   Then assert rst during ACK2: vector_valid drops asynchronously and the FSM is in IDLE.
